// File: rtl/hmc_arb_pkg.sv
// Shared arbiter state encoding, decoded identically by the sequencer and its bench.
package hmc_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

  // Counter width that holds 0..max; a zero limit still needs one bit.
  function automatic int hold_width(input int max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set req bit at or after ptr, wrapping; purely combinational.
// Zero latency, no backpressure; valid low when req is empty.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the farthest rotated position down so the nearest-to-ptr hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int pos;
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        idx   = IW'(pos);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared data bus: grant one cycle after request, one idle turnaround between owners.
// Owner keeps the bus until done, req drop, or MAXHOLD consecutive cycles (forced revoke pulses timeout).
module bus_arbiter
  import hmc_arb_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int MAXHOLD = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          timeout
);

  localparam int HW = hold_width(MAXHOLD);
  localparam logic [HW-1:0] LIMIT = HW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          timeout_q, timeout_nxt;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          rel_normal;
  logic          at_limit;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign rel_normal = done[owner] | ~req[owner];
  assign at_limit   = (MAXHOLD != 0) && (hold_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    unique case (state)
      ARB_IDLE, ARB_TURN: begin
        if (pick_valid) begin
          state_nxt = ARB_GRANT;
          owner_nxt = pick_idx;
          hold_nxt  = '0;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (rel_normal || at_limit) begin
          state_nxt   = ARB_TURN;
          ptr_nxt     = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
          // A normal release on the limit cycle wins over the revoke.
          timeout_nxt = at_limit && !rel_normal;
        end else if (hold_cnt != '1) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign busy     = (state == ARB_GRANT);
  assign grant_id = busy ? owner : '0;
  assign timeout  = timeout_q;

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = busy && (owner == IW'(i));
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed + random bench for bus_arbiter against a cycle-level ownership model.
module tb_bus_arbiter;

  localparam int N       = 4;
  localparam int MAXHOLD = 8;
  localparam int IW      = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout;

  int tests = 0;
  int fails = 0;

  bus_arbiter #(.N(N), .MAXHOLD(MAXHOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 = nobody), how long they have held it, rotation pointer.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  function automatic int rr_first(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      bit released, forced;
      m_held++;
      released = done[m_owner] || !req[m_owner];
      forced   = (MAXHOLD > 0) && (m_held >= MAXHOLD) && !released;
      m_to     = forced;
      if (released || forced) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      m_to    = 1'b0;
      m_owner = rr_first(req, m_ptr);
      m_held  = 0;
    end
    #1;
    chk("grant",    int'(grant),    (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("grant_id", int'(grant_id), (m_owner >= 0) ? m_owner : 0);
    chk("busy",     int'(busy),     int'(m_owner >= 0));
    chk("timeout",  int'(timeout),  int'(m_to));
    chk("onehot0",  int'($onehot0(grant)), 1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; req = '0; done = '0;

    // 1: reset held with all requesting
    req = 4'b1111;
    repeat (3) step();
    chk("t1_rst_grant", int'(grant), 0);
    chk("t1_rst_busy",  int'(busy),  0);
    reset = 1'b0;
    step();
    chk("t1_first_grant", int'(grant), 4'b0001);
    req = '0;
    step(); step();

    // 2: single requester, done after three grant cycles
    req = 4'b0100;
    step(); chk("t2_g1", int'(grant), 4'b0100);
    step(); chk("t2_g2", int'(grant), 4'b0100);
    step(); chk("t2_g3", int'(grant), 4'b0100);
    done = 4'b0100;
    step(); chk("t2_turn", int'(grant), 0);
    done = '0; req = '0;
    step(); chk("t2_idle", int'(busy), 0);

    // 3: everyone requesting, each owner releases after one cycle
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t3_owner", int'(grant), int'(seq[k]));
      done = seq[k];
      step();
      chk("t3_gap", int'(grant), 0);
      done = '0;
      step();
    end
    req = '0;
    step(); step();

    // 4: hung owner gets revoked after exactly MAXHOLD cycles
    req = 4'b0001;
    step();
    for (int c = 0; c < 8; c++) begin
      chk("t4_hold", int'(grant), 4'b0001);
      chk("t4_no_to", int'(timeout), 0);
      step();
    end
    chk("t4_revoked", int'(grant), 0);
    chk("t4_timeout", int'(timeout), 1);
    step();
    chk("t4_regrant", int'(grant), 4'b0001);
    chk("t4_to_clear", int'(timeout), 0);
    req = '0;
    step(); step();

    // 5: done on the limit cycle is a normal release; stray done from a non-owner
    req = 4'b0001;
    step();
    for (int c = 1; c < 8; c++) begin
      done = (c == 3) ? 4'b1000 : 4'b0000;
      step();
    end
    chk("t5_last_cycle", int'(grant), 4'b0001);
    done = 4'b0001;
    step();
    chk("t5_release", int'(grant), 0);
    chk("t5_no_to", int'(timeout), 0);
    done = '0; req = '0;
    step(); step();

    // 6: reset mid-grant, then random traffic
    req = 4'b0010;
    step(); chk("t6_owner", int'(grant), 4'b0010);
    reset = 1'b1;
    step();
    chk("t6_rst_grant", int'(grant), 0);
    chk("t6_rst_to", int'(timeout), 0);
    reset = 1'b0; req = 4'b0011;
    step(); chk("t6_ptr0", int'(grant), 4'b0001);
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        done[i] = ($urandom_range(15) == 0);
      end
      step();
    end
    req = '0; done = '0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
